// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types, spawn/corner constants and helpers for the
// ghost move scheduler and its mode timer.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        FRIGHT  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        REQ   = 2'd2,
        ISSUE = 2'd3
    } seq_state_t;

    localparam logic [4:0] SPAWN_X  = 5'd10;
    localparam logic [4:0] SPAWN_Y0 = 5'd10;
    localparam logic [4:0] SPAWN_Y1 = 5'd11;

    // Home corner per ghost index while scattering.
    localparam logic [4:0] SCATTER_CORNER_X [4] = '{5'd27, 5'd0, 5'd27, 5'd0};
    localparam logic [4:0] SCATTER_CORNER_Y [4] = '{5'd0,  5'd0, 5'd31, 5'd31};

    // Wide enough for the longest mode phase (CHASE_TICKS up to 255).
    localparam int unsigned MODE_CNT_W = 8;

    function automatic logic at_spawn(input logic [4:0] x, input logic [4:0] y);
        return (x == SPAWN_X) && ((y == SPAWN_Y0) || (y == SPAWN_Y1));
    endfunction

endpackage

// File: rtl/ghost_mode_timer.sv
// ghost_mode_timer: global SCATTER/CHASE/FRIGHT mode sequencer. Advances on
// accepted move_ticks only. FRIGHT support (power pellet, saved mode/count)
// exists only when GHOST_FRIGHT_EN is defined.
module ghost_mode_timer
    import ghost_pkg::*;
#(
    parameter int unsigned SCATTER_TICKS = 56,
    parameter int unsigned CHASE_TICKS   = 160,
    parameter int unsigned FRIGHT_TICKS  = 48
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_tick,
    input  logic       power_pellet,
    output logic [1:0] mode
);

    localparam logic [MODE_CNT_W-1:0] SCATTER_LAST = MODE_CNT_W'(SCATTER_TICKS - 1);
    localparam logic [MODE_CNT_W-1:0] CHASE_LAST   = MODE_CNT_W'(CHASE_TICKS - 1);

    mode_t                 mode_q, mode_d;
    logic [MODE_CNT_W-1:0] cnt_q, cnt_d;

`ifdef GHOST_FRIGHT_EN
    localparam logic [MODE_CNT_W-1:0] FRIGHT_LAST = MODE_CNT_W'(FRIGHT_TICKS - 1);

    mode_t                 saved_mode_q, saved_mode_d;
    logic [MODE_CNT_W-1:0] saved_cnt_q, saved_cnt_d;
`else
    localparam int unsigned unused_fright_ticks = FRIGHT_TICKS;
    logic unused_pellet;
    assign unused_pellet = power_pellet;
`endif

    // Mode state and phase counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q       <= SCATTER;
            cnt_q        <= '0;
`ifdef GHOST_FRIGHT_EN
            saved_mode_q <= SCATTER;
            saved_cnt_q  <= '0;
`endif
        end else begin
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
`ifdef GHOST_FRIGHT_EN
            saved_mode_q <= saved_mode_d;
            saved_cnt_q  <= saved_cnt_d;
`endif
        end
    end

    // Next mode: a pellet takes priority over a tick in the same cycle.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
`ifdef GHOST_FRIGHT_EN
        saved_mode_d = saved_mode_q;
        saved_cnt_d  = saved_cnt_q;
        if (power_pellet) begin
            // Only snapshot when entering FRIGHT; a repeat pellet just restarts it.
            if (mode_q != FRIGHT) begin
                saved_mode_d = mode_q;
                saved_cnt_d  = cnt_q;
            end
            mode_d = FRIGHT;
            cnt_d  = '0;
        end else
`endif
        if (move_tick) begin
            case (mode_q)
                SCATTER: begin
                    if (cnt_q == SCATTER_LAST) begin
                        mode_d = CHASE;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CHASE: begin
                    if (cnt_q == CHASE_LAST) begin
                        mode_d = SCATTER;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef GHOST_FRIGHT_EN
                FRIGHT: begin
                    if (cnt_q == FRIGHT_LAST) begin
                        mode_d = saved_mode_q;
                        cnt_d  = saved_cnt_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    mode_d = SCATTER;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    assign mode = mode_q;

endmodule

// File: rtl/ghost_move_sched.sv
// ghost_move_sched: per-tick ghost movement scheduler. Serves ghosts in index
// order through one shared direction-decision unit and emits one step per
// ghost per move_tick. Optional FRIGHT mode is enabled by GHOST_FRIGHT_EN.
module ghost_move_sched
    import ghost_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS    = 4,
    parameter int unsigned SCATTER_TICKS = 56,
    parameter int unsigned CHASE_TICKS   = 160,
    parameter int unsigned FRIGHT_TICKS  = 48
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    move_tick,
    input  logic                    power_pellet,
    input  logic [4:0]              pac_x,
    input  logic [4:0]              pac_y,
    input  logic [5*NUM_GHOSTS-1:0] ghost_x,
    input  logic [5*NUM_GHOSTS-1:0] ghost_y,
    output logic                    dec_req,
    output logic [4:0]              dec_src_x,
    output logic [4:0]              dec_src_y,
    output logic [4:0]              dec_tgt_x,
    output logic [4:0]              dec_tgt_y,
    input  logic                    dec_ack,
    input  logic [1:0]              dec_dir,
    output logic                    step_valid,
    output logic [1:0]              step_id,
    output logic [1:0]              step_dir,
    output logic [1:0]              mode,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_GHOSTS - 1);

    seq_state_t state_q, state_d;
    logic [1:0] idx_q;
    dir_t       dir_q;
    mode_t      round_mode_q, round_mode_d;
    logic [4:0] src_x_q, src_y_q, tgt_x_q, tgt_y_q;

    logic [NUM_GHOSTS-1:0][4:0] gx_arr, gy_arr;
    logic [4:0] cur_x, cur_y, tgt_x, tgt_y;
    logic [1:0] timer_mode;
    logic       tick_start, timer_tick, pellet_now;

    assign gx_arr = ghost_x;
    assign gy_arr = ghost_y;
    assign cur_x  = gx_arr[idx_q];
    assign cur_y  = gy_arr[idx_q];

    assign tick_start = move_tick && (state_q == IDLE);

`ifdef GHOST_FRIGHT_EN
    assign pellet_now   = power_pellet;
    assign round_mode_d = pellet_now ? FRIGHT : mode_t'(timer_mode);
`else
    assign pellet_now   = 1'b0;
    assign round_mode_d = mode_t'(timer_mode);
`endif

    // A tick that coincides with a pellet starts a round but is not counted.
    assign timer_tick = tick_start && !pellet_now;

    ghost_mode_timer #(
        .SCATTER_TICKS (SCATTER_TICKS),
        .CHASE_TICKS   (CHASE_TICKS),
        .FRIGHT_TICKS  (FRIGHT_TICKS)
    ) u_mode_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .move_tick    (timer_tick),
        .power_pellet (power_pellet),
        .mode         (timer_mode)
    );

    assign mode = timer_mode;

    // Target for the ghost being served, using the mode captured at the tick.
    always_comb begin
        tgt_x = SCATTER_CORNER_X[idx_q];
        tgt_y = SCATTER_CORNER_Y[idx_q];
        case (round_mode_q)
            CHASE: begin
                tgt_x = pac_x;
                tgt_y = pac_y;
            end
`ifdef GHOST_FRIGHT_EN
            FRIGHT: begin
                tgt_x = 5'd31 - pac_x;
                tgt_y = 5'd31 - pac_y;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Sequencer next state and handshake/step outputs.
    always_comb begin
        state_d    = state_q;
        dec_req    = 1'b0;
        step_valid = 1'b0;
        step_id    = '0;
        step_dir   = '0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE:  if (tick_start) state_d = SEL;
            SEL:   state_d = at_spawn(cur_x, cur_y) ? ISSUE : REQ;
            REQ: begin
                dec_req = 1'b1;
                if (dec_ack) state_d = ISSUE;
            end
            ISSUE: begin
                step_valid = 1'b1;
                step_id    = idx_q;
                step_dir   = dir_q;
                state_d    = (idx_q == LAST_IDX) ? IDLE : SEL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round datapath: ghost index, captured mode, request fields, direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= '0;
            dir_q        <= UP;
            round_mode_q <= SCATTER;
            src_x_q      <= '0;
            src_y_q      <= '0;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
        end else begin
            if (tick_start) begin
                idx_q        <= '0;
                round_mode_q <= round_mode_d;
            end
            // Request fields are frozen here so they stay stable through REQ.
            if (state_q == SEL) begin
                src_x_q <= cur_x;
                src_y_q <= cur_y;
                tgt_x_q <= tgt_x;
                tgt_y_q <= tgt_y;
                if (at_spawn(cur_x, cur_y)) dir_q <= UP;
            end
            if ((state_q == REQ) && dec_ack) dir_q <= dir_t'(dec_dir);
            if ((state_q == ISSUE) && (idx_q != LAST_IDX)) idx_q <= idx_q + 2'd1;
        end
    end

    // Sticky flag for ticks that arrive while a round is still running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           overrun <= 1'b0;
        else if (move_tick && (state_q != IDLE)) overrun <= 1'b1;
    end

    assign dec_src_x = src_x_q;
    assign dec_src_y = src_y_q;
    assign dec_tgt_x = tgt_x_q;
    assign dec_tgt_y = tgt_y_q;

endmodule
